// File: rtl/tick_period_monitor_pkg.sv
// Shared definitions for the tick period monitor: state encodings and error counter helpers.
package tick_period_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_e;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Clear wins over the old value but still counts an event that lands in the same cycle.
    function automatic logic [ERR_W-1:0] err_next(input logic [ERR_W-1:0] cur,
                                                  input logic clr,
                                                  input logic evt);
        if (clr) begin
            return evt ? ERR_W'(1) : '0;
        end
        if (evt && (cur != ERR_MAX)) begin
            return cur + 1'b1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/tick_period_monitor_if.sv
// Control and report signals between the tick period monitor and its consumer.
interface tick_period_monitor_if #(
    parameter int WIDTH = 18
);
    import tick_period_monitor_pkg::*;

    logic             enable;
    logic             tick_in;
    logic             clear_err;
    logic [WIDTH-1:0] period_out;
    logic             period_valid;
    logic             early_err;
    logic             timeout_err;
    logic             locked;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] avg_period;

    modport master (
        input  enable, tick_in, clear_err,
        output period_out, period_valid, early_err, timeout_err, locked, err_count, avg_period
    );

    modport slave (
        output enable, tick_in, clear_err,
        input  period_out, period_valid, early_err, timeout_err, locked, err_count, avg_period
    );

endinterface

// File: rtl/tick_period_monitor_counter.sv
// Interval counter for the tick period monitor, with a compare flag at the timeout terminal value.
module tick_interval_counter #(
    parameter int WIDTH    = 18,
    parameter int TERMINAL = 200001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/tick_period_monitor.sv
// Measures the interval between tick_in pulses, flags early/overdue ticks and tracks lock.
// Define TICK_MON_AVG_EN to build a 4-sample running average on avg_period.
module tick_period_monitor
    import tick_period_monitor_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int EXPECTED = 200000,
    parameter int TOL      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    tick_period_monitor_if.master mon
);

    localparam int LOWER = EXPECTED - TOL;
    localparam int UPPER = EXPECTED + TOL;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] measured;
    logic [WIDTH-1:0] period_q;
    logic             period_valid_q;
    logic             early_q;
    logic             timeout_q;
    logic             locked_q;
    logic [ERR_W-1:0] err_q;
    logic             at_terminal;
    logic             active;
    logic             report;
    logic             early_evt;
    logic             timeout_evt;
    logic             cnt_inc;

    assign active      = mon.enable && (state_q == ST_TRACK);
    assign report      = active && mon.tick_in;
    assign timeout_evt = active && !mon.tick_in && at_terminal;
    assign measured    = cnt + WIDTH'(1);
    assign early_evt   = report && (measured < WIDTH'(LOWER));
    // Counting only happens mid-interval in TRACK; every other case returns the counter to zero.
    assign cnt_inc     = active && !mon.tick_in && !at_terminal;

    tick_interval_counter #(
        .WIDTH    (WIDTH),
        .TERMINAL (UPPER - 1)
    ) u_counter (
        .clock       (clock),
        .reset       (reset),
        .clear       (!cnt_inc),
        .inc         (cnt_inc),
        .count       (cnt),
        .at_terminal (at_terminal)
    );

    // NOTE: always_comb assigns a default first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (!mon.enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ACQUIRE;
                ST_ACQUIRE: if (mon.tick_in) state_d = ST_TRACK;
                ST_TRACK:   if (timeout_evt) state_d = ST_ACQUIRE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            early_q        <= 1'b0;
            timeout_q      <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= '0;
        end else begin
            state_q        <= state_d;
            locked_q       <= (state_d == ST_TRACK);
            period_valid_q <= report;
            early_q        <= early_evt;
            timeout_q      <= timeout_evt;
            err_q          <= err_next(err_q, mon.clear_err, early_evt || timeout_evt);
            if (report) begin
                period_q <= measured;
            end
        end
    end

    assign mon.period_out   = period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.early_err    = early_q;
    assign mon.timeout_err  = timeout_q;
    assign mon.locked       = locked_q;
    assign mon.err_count    = err_q;

`ifdef TICK_MON_AVG_EN
    logic [WIDTH-1:0] hist [3];
    logic [1:0]       hist_n;
    logic [WIDTH-1:0] avg_q;
    logic [WIDTH+1:0] sum4;

    assign sum4 = (WIDTH+2)'(measured) + (WIDTH+2)'(hist[0])
                + (WIDTH+2)'(hist[1]) + (WIDTH+2)'(hist[2]);

    // hist holds the three samples before the current one; hist_n saturates once all three are valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist   <= '{default: '0};
            hist_n <= '0;
            avg_q  <= '0;
        end else if (state_d != ST_TRACK) begin
            hist   <= '{default: '0};
            hist_n <= '0;
            avg_q  <= period_q;
        end else if (report) begin
            hist[0] <= measured;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            if (hist_n != 2'd3) begin
                hist_n <= hist_n + 1'b1;
                avg_q  <= measured;
            end else begin
                avg_q  <= sum4[WIDTH+1:2];
            end
        end
    end

    assign mon.avg_period = avg_q;
`else
    assign mon.avg_period = period_q;
`endif

endmodule
